// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared constants for the register bank
// Purpose: default geometry, the hard-wired zero register index and the
//          default stack-pointer register index/reset value.
// Ports:   none (package).
package register_bank_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int ZERO_REG           = 0;
  localparam int DEFAULT_SP_INDEX   = 2;
  localparam int DEFAULT_SP_RESET   = 252;

endpackage

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - read/write/reserve bus of the register bank
// Purpose: bundles the two read ports, the write port and the reserve port.
// Ports:   master drives indices, enables and write data;
//          slave returns read data, busy bits and the reserve-conflict pulse.
interface register_bank_if
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  readEnable;
  logic [DATA_WIDTH-1:0] outRS1;
  logic [DATA_WIDTH-1:0] outRS2;
  logic                  busyRS1;
  logic                  busyRS2;
  logic [ADDR_WIDTH-1:0] rsWrite;
  logic [DATA_WIDTH-1:0] dataWrite;
  logic                  rWrite;
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] rsReserve;
  logic                  reserveConflict;

  modport master (
    output rs1, rs2, readEnable, rsWrite, dataWrite, rWrite, reserve, rsReserve,
    input  outRS1, outRS2, busyRS1, busyRS2, reserveConflict
  );

  modport slave (
    input  rs1, rs2, readEnable, rsWrite, dataWrite, rWrite, reserve, rsReserve,
    output outRS1, outRS2, busyRS1, busyRS2, reserveConflict
  );

endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy (pending write) tracking
// Purpose: a write clears the busy bit of its target, a reserve sets it; when
//          both hit the same index in one cycle the reserve wins. Reserving a
//          register that is already busy (and not being written) raises a
//          one-cycle registered conflict pulse.
// Ports:   clock, reset          - clock, synchronous active-high reset
//          write_en, write_index - write strobe and target
//          reserve_en, reserve_index - reserve strobe and target
//          busy                  - current busy vector (bit 0 always 0)
//          conflict              - registered reserve-conflict pulse
module reg_scoreboard
  import register_bank_pkg::*;
#(
  parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_index,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  conflict
);

  logic write_hit;
  logic reserve_hit;

  // Index 0 is hard-wired, so strobes aimed at it are dropped here.
  assign write_hit   = write_en   && (write_index   != ADDR_WIDTH'(ZERO_REG));
  assign reserve_hit = reserve_en && (reserve_index != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= '0;
      conflict <= 1'b0;
    end else begin
      // A register being written this cycle is being released, so
      // re-reserving it is a hand-over rather than a conflict.
      conflict <= reserve_hit && busy[reserve_index] &&
                  !(write_hit && (write_index == reserve_index));
      if (write_hit) begin
        busy[write_index] <= 1'b0;
      end
      // Applied after the clear so a same-index reserve ends set.
      if (reserve_hit) begin
        busy[reserve_index] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - register file with two read ports and busy tracking
// Purpose: NUM_REGS registers (register 0 reads as zero), one write port with
//          write-through bypass to the read ports, registered read data and
//          busy bits, and a reserve port feeding the busy scoreboard.
// Ports:   clock - sole clock, rising edge
//          reset - synchronous active-high reset
//          bus   - register_bank_if slave: rs1/rs2/readEnable read request,
//                  outRS1/outRS2/busyRS1/busyRS2 registered read response,
//                  rsWrite/dataWrite/rWrite write, reserve/rsReserve reserve,
//                  reserveConflict registered conflict pulse
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter  int SP_INDEX   = DEFAULT_SP_INDEX,
  parameter  int SP_RESET   = DEFAULT_SP_RESET,
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input logic            clock,
  input logic            reset,
  register_bank_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] SP_VALUE = DATA_WIDTH'(SP_RESET);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  write_hit;
  logic [DATA_WIDTH:0]   port1;
  logic [DATA_WIDTH:0]   port2;

  assign write_hit = bus.rWrite && (bus.rsWrite != ADDR_WIDTH'(ZERO_REG));

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .write_en      (bus.rWrite),
    .write_index   (bus.rsWrite),
    .reserve_en    (bus.reserve),
    .reserve_index (bus.rsReserve),
    .busy          (busy),
    .conflict      (bus.reserveConflict)
  );

  // Returns {busy, data} as seen by a read port this cycle. A same-cycle
  // write is forwarded (and reported not busy); a same-cycle reserve is not,
  // so the port sees the pre-edge busy bit.
  function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (write_hit && (idx == bus.rsWrite)) begin
      return {1'b0, bus.dataWrite};
    end else if (idx == ADDR_WIDTH'(ZERO_REG)) begin
      return '0;
    end else begin
      return {busy[idx], regs[idx]};
    end
  endfunction

  always_comb begin
    port1 = read_port(bus.rs1);
    port2 = read_port(bus.rs2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= ((i == SP_INDEX) && (SP_INDEX != ZERO_REG)) ? SP_VALUE : '0;
      end
    end else if (write_hit) begin
      regs[bus.rsWrite] <= bus.dataWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.outRS1  <= '0;
      bus.outRS2  <= '0;
      bus.busyRS1 <= 1'b0;
      bus.busyRS2 <= 1'b0;
    end else if (bus.readEnable) begin
      bus.outRS1  <= port1[DATA_WIDTH-1:0];
      bus.outRS2  <= port2[DATA_WIDTH-1:0];
      bus.busyRS1 <= port1[DATA_WIDTH];
      bus.busyRS2 <= port2[DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - scoreboard bench for register_bank (32/5 and 16/3)
module tb_register_bank;

  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
    logic        b1;
    logic        b2;
    logic        c;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
  register_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus1 ();

  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INDEX(2), .SP_RESET(252)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .SP_INDEX(2), .SP_RESET(252)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pop0  = 0;
  int   pop1  = 0;

  // Reference model: architectural register contents, busy flags and the
  // last visible outputs, one copy per configuration.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  exp_t        m_out  [2];

  task automatic model_step(input int d, input bit rst, input bit re, input int r1,
                            input int r2, input bit rw, input int wi, input logic [31:0] wd,
                            input bit res, input int ri, output exp_t e);
    int          amask;
    logic [31:0] dmask;
    int          a1, a2, aw, ar;
    logic [31:0] wdm;
    bit          wr_ok, rs_ok;
    amask = (d == 0) ? 31 : 7;
    dmask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a1 = r1 & amask; a2 = r2 & amask; aw = wi & amask; ar = ri & amask;
    wdm = wd & dmask;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[d][i] = 32'h0;
        m_busy[d][i] = 1'b0;
      end
      m_regs[d][2] = 32'd252 & dmask;
      m_out[d] = '0;
    end else begin
      wr_ok = rw && (aw != 0);
      rs_ok = res && (ar != 0);
      m_out[d].c = rs_ok && m_busy[d][ar] && !(wr_ok && aw == ar);
      if (re) begin
        if (wr_ok && aw == a1) begin m_out[d].o1 = wdm; m_out[d].b1 = 1'b0; end
        else begin m_out[d].o1 = (a1 == 0) ? 32'h0 : m_regs[d][a1]; m_out[d].b1 = m_busy[d][a1]; end
        if (wr_ok && aw == a2) begin m_out[d].o2 = wdm; m_out[d].b2 = 1'b0; end
        else begin m_out[d].o2 = (a2 == 0) ? 32'h0 : m_regs[d][a2]; m_out[d].b2 = m_busy[d][a2]; end
      end
      if (wr_ok) begin m_regs[d][aw] = wdm; m_busy[d][aw] = 1'b0; end
      if (rs_ok) m_busy[d][ar] = 1'b1;
    end
    e = m_out[d];
  endtask

  task automatic step(input bit rst, input bit re, input int r1, input int r2,
                      input bit rw, input int wi, input logic [31:0] wd,
                      input bit res, input int ri);
    exp_t e;
    reset          = rst;
    bus0.readEnable = re;     bus1.readEnable = re;
    bus0.rs1       = r1[4:0]; bus1.rs1       = r1[2:0];
    bus0.rs2       = r2[4:0]; bus1.rs2       = r2[2:0];
    bus0.rWrite    = rw;      bus1.rWrite    = rw;
    bus0.rsWrite   = wi[4:0]; bus1.rsWrite   = wi[2:0];
    bus0.dataWrite = wd;      bus1.dataWrite = wd[15:0];
    bus0.reserve   = res;     bus1.reserve   = res;
    bus0.rsReserve = ri[4:0]; bus1.rsReserve = ri[2:0];
    model_step(0, rst, re, r1, r2, rw, wi, wd, res, ri, e);
    q0.push_back(e);
    model_step(1, rst, re, r1, r2, rw, wi, wd, res, ri, e);
    q1.push_back(e);
    @(posedge clock);
    #1;
  endtask

  exp_t e0, e1, g0, g1;

  always @(negedge clock) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      g0 = {bus0.outRS1, bus0.outRS2, bus0.busyRS1, bus0.busyRS2, bus0.reserveConflict};
      n_cmp++;
      if (g0 !== e0) begin
        n_bad++;
        $display("FAIL cfg32 #%0d: got o1=%h o2=%h b1=%b b2=%b c=%b, expected o1=%h o2=%h b1=%b b2=%b c=%b",
                 pop0, g0.o1, g0.o2, g0.b1, g0.b2, g0.c, e0.o1, e0.o2, e0.b1, e0.b2, e0.c);
      end
      pop0++;
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      g1 = {16'h0, bus1.outRS1, 16'h0, bus1.outRS2, bus1.busyRS1, bus1.busyRS2, bus1.reserveConflict};
      n_cmp++;
      if (g1 !== e1) begin
        n_bad++;
        $display("FAIL cfg16 #%0d: got o1=%h o2=%h b1=%b b2=%b c=%b, expected o1=%h o2=%h b1=%b b2=%b c=%b",
                 pop1, g1.o1, g1.o2, g1.b1, g1.b2, g1.c, e1.o1, e1.o2, e1.b1, e1.b2, e1.c);
      end
      pop1++;
    end
  end

  initial begin
    int r1, r2, wi, ri;
    bit re, rw, res, rst;
    // Reset, including a read request that reset must override.
    step(1, 1, 2, 5, 1, 7, 32'h1111_1111, 1, 9);
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    // SP register and a plain zero register after reset.
    step(0, 1, 2, 5, 0, 0, 32'h0, 0, 0);
    step(0, 0, 7, 7, 0, 0, 32'h0, 0, 0);
    // Write-through bypass.
    step(0, 1, 7, 2, 1, 7, 32'hDEAD_BEEF, 0, 0);
    step(0, 1, 7, 7, 0, 0, 32'h0, 0, 0);
    // Register 0 ignores writes and reserves.
    step(0, 0, 0, 0, 1, 0, 32'h1234, 1, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    // Reserve, busy visible, conflict pulse, release by write.
    step(0, 1, 0, 9, 0, 0, 32'h0, 1, 9);
    step(0, 1, 0, 9, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1, 9);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 32'h55, 0, 0);
    step(0, 1, 0, 9, 0, 0, 32'h0, 0, 0);
    // Reserve and write the same register in one cycle: reserve wins.
    step(0, 0, 0, 0, 1, 4, 32'hA5, 1, 4);
    step(0, 1, 0, 4, 0, 0, 32'h0, 0, 0);
    // Reserve reg 4 again while it is being written: no conflict.
    step(0, 1, 4, 4, 1, 4, 32'h5A, 1, 4);
    // Reserve not bypassed to a same-cycle read.
    step(0, 1, 6, 6, 0, 0, 32'h0, 1, 6);
    // Pending reservation and write discarded by reset.
    step(0, 0, 0, 0, 1, 3, 32'h77, 1, 3);
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step(0, 1, 3, 2, 0, 0, 32'h0, 0, 0);
    // Randomised traffic with a bias towards low indices for collisions.
    for (int n = 0; n < 600; n++) begin
      r1  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      wi  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      ri  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      re  = ($urandom_range(0, 3) != 0);
      rw  = ($urandom_range(0, 1) == 0);
      res = ($urandom_range(0, 4) < 2);
      rst = ($urandom_range(0, 63) == 0);
      step(rst, re, r1, r2, rw, wi, $urandom, res, ri);
    end
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 4 && (q0.size() > 0 || q1.size() > 0); k++) begin
      @(negedge clock);
      #1;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
